// File: rtl/pong_pkg.sv
// pong_pkg: shared coordinate, score, state and direction definitions for playfield objects
package pong_pkg;
  localparam int COORD_W = 12;
  localparam int SCORE_W = 8;
  typedef logic [COORD_W-1:0] coord_t;
  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;
  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;
endpackage

// File: rtl/pong_ball_if.sv
// pong_ball_if: strobe/serve/paddle-box inputs and ball-box/HUD outputs; PONG_BALL_LIVES_EN adds o_lives
interface pong_ball_if;
  import pong_pkg::*;
  logic i_ani_stb, i_animate, i_serve;
  coord_t i_pad_x1, i_pad_x2, i_pad_y1, i_pad_y2;
  coord_t o_x1, o_x2, o_y1, o_y2;
  logic o_hit, o_miss;
  logic [SCORE_W-1:0] o_score;
  logic [1:0] o_state;
`ifdef PONG_BALL_LIVES_EN
  logic [1:0] o_lives;
  modport master(output i_ani_stb, i_animate, i_serve, i_pad_x1, i_pad_x2, i_pad_y1, i_pad_y2,
                 input o_x1, o_x2, o_y1, o_y2, o_hit, o_miss, o_score, o_state, o_lives);
  modport slave(input i_ani_stb, i_animate, i_serve, i_pad_x1, i_pad_x2, i_pad_y1, i_pad_y2,
                output o_x1, o_x2, o_y1, o_y2, o_hit, o_miss, o_score, o_state, o_lives);
`else
  modport master(output i_ani_stb, i_animate, i_serve, i_pad_x1, i_pad_x2, i_pad_y1, i_pad_y2,
                 input o_x1, o_x2, o_y1, o_y2, o_hit, o_miss, o_score, o_state);
  modport slave(input i_ani_stb, i_animate, i_serve, i_pad_x1, i_pad_x2, i_pad_y1, i_pad_y2,
                output o_x1, o_x2, o_y1, o_y2, o_hit, o_miss, o_score, o_state);
`endif
endinterface

// File: rtl/pong_ball_box_overlap.sv
// box_overlap: combinational 1-D closed-interval overlap test
module box_overlap
  import pong_pkg::*;
(
  input  coord_t a_lo,
  input  coord_t a_hi,
  input  coord_t b_lo,
  input  coord_t b_hi,
  output logic   hit
);
  assign hit = (a_hi >= b_lo) && (a_lo <= b_hi);
endmodule

// File: rtl/pong_ball.sv
// pong_ball: serve/bounce/score ball object; PONG_BALL_LIVES_EN enables lives and the OVER state
module pong_ball
  import pong_pkg::*;
#(
  parameter int H_SIZE       = 8,
  parameter int IX           = 320,
  parameter int IY           = 240,
  parameter int D_WIDTH      = 640,
  parameter int D_HEIGHT     = 480,
  parameter int SPEED        = 2,
  parameter int SERVE_FRAMES = 60
)(
  input logic      i_clk,
  input logic      i_rst,
  pong_ball_if.slave bus
);
  localparam coord_t HS   = coord_t'(H_SIZE);
  localparam coord_t SP   = coord_t'(SPEED);
  localparam coord_t CX   = coord_t'(IX);
  localparam coord_t CY   = coord_t'(IY);
  localparam coord_t XR   = coord_t'(D_WIDTH - 1);
  localparam coord_t YB   = coord_t'(D_HEIGHT - 1);
  localparam coord_t XMAX = coord_t'(D_WIDTH - 1 - H_SIZE);
  localparam int CW = $clog2(SERVE_FRAMES + 1);
  localparam logic [CW-1:0] SF = CW'(SERVE_FRAMES);
  state_t st, st_n;
  coord_t x, x_n, y, y_n, mx, my;
  logic dx, dx_n, dy, dy_n, mdx, mdy;
  logic [CW-1:0] cnt, cnt_n;
  logic [SCORE_W-1:0] score, score_n;
  logic hit, hit_n, miss, miss_n;
  logic ov, wall_l, wall_r, wall_t, p_hit, p_miss, upd;
`ifdef PONG_BALL_LIVES_EN
  logic [1:0] lives, lives_n;
`endif
  box_overlap u_ov (.a_lo(x - HS), .a_hi(x + HS), .b_lo(bus.i_pad_x1), .b_hi(bus.i_pad_x2), .hit(ov));
  assign upd    = bus.i_ani_stb && bus.i_animate;
  assign wall_l = (dx == DIR_NEG) && (x <= HS + SP);
  assign wall_r = (dx == DIR_POS) && (x + HS + SP >= XR);
  assign wall_t = (dy == DIR_NEG) && (y <= HS + SP);
  assign p_hit  = (dy == DIR_POS) && (y + HS < bus.i_pad_y1) && (y + HS + SP >= bus.i_pad_y1) && ov;
  assign p_miss = (dy == DIR_POS) && !p_hit && (y + HS + SP >= YB);
  assign mx     = wall_l ? HS : wall_r ? XMAX : (dx == DIR_NEG) ? x - SP : x + SP;
  assign mdx    = wall_l ? DIR_POS : wall_r ? DIR_NEG : dx;
  assign my     = wall_t ? HS : p_hit ? bus.i_pad_y1 - HS - 1'b1 : (dy == DIR_NEG) ? y - SP : y + SP;
  assign mdy    = wall_t ? DIR_POS : p_hit ? DIR_NEG : dy;
  // next-state: park/serve, serve countdown, then per-strobe motion with paddle > miss > move
  always_comb begin
    st_n = st;
    x_n = x;
    y_n = y;
    dx_n = dx;
    dy_n = dy;
    cnt_n = cnt;
    score_n = score;
    hit_n = 1'b0;
    miss_n = 1'b0;
`ifdef PONG_BALL_LIVES_EN
    lives_n = lives;
`endif
    if (upd) begin
      if (st == IDLE || st == OVER) begin
        x_n = CX;
        y_n = CY;
        if (bus.i_serve) begin
          st_n = SERVE;
          cnt_n = '0;
          dx_n = DIR_POS;
          dy_n = DIR_NEG;
`ifdef PONG_BALL_LIVES_EN
          if (st == OVER) begin
            lives_n = 2'd3;
            score_n = '0;
          end
`endif
        end
      end else if (st == SERVE && cnt != SF) begin
        cnt_n = cnt + 1'b1;
      end else begin
        st_n = PLAY;
        x_n = mx;
        y_n = my;
        dx_n = mdx;
        dy_n = mdy;
        hit_n = p_hit;
        score_n = (p_hit && score != '1) ? score + 1'b1 : score;
        if (p_miss) begin
          miss_n = 1'b1;
          x_n = CX;
          y_n = CY;
`ifdef PONG_BALL_LIVES_EN
          lives_n = lives - 1'b1;
          st_n = (lives == 2'd1) ? OVER : IDLE;
`else
          st_n = IDLE;
`endif
        end
      end
    end
  end
  // state register with synchronous reset to the serve position
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st <= IDLE;
      x <= CX;
      y <= CY;
      dx <= DIR_POS;
      dy <= DIR_NEG;
      cnt <= '0;
      score <= '0;
      hit <= 1'b0;
      miss <= 1'b0;
`ifdef PONG_BALL_LIVES_EN
      lives <= 2'd3;
`endif
    end else begin
      st <= st_n;
      x <= x_n;
      y <= y_n;
      dx <= dx_n;
      dy <= dy_n;
      cnt <= cnt_n;
      score <= score_n;
      hit <= hit_n;
      miss <= miss_n;
`ifdef PONG_BALL_LIVES_EN
      lives <= lives_n;
`endif
    end
  end
  assign bus.o_x1    = x - HS;
  assign bus.o_x2    = x + HS;
  assign bus.o_y1    = y - HS;
  assign bus.o_y2    = y + HS;
  assign bus.o_hit   = hit;
  assign bus.o_miss  = miss;
  assign bus.o_score = score;
  assign bus.o_state = st;
`ifdef PONG_BALL_LIVES_EN
  assign bus.o_lives = lives;
`endif
endmodule

// File: tb/tb_pong_ball.sv
// tb_pong_ball: scoreboard bench for pong_ball; honours PONG_BALL_LIVES_EN
module tb_pong_ball;
  import pong_pkg::*;
  localparam int H = 8, S = 2, CXI = 320, CYI = 240, W = 640, HT = 480, SF = 60;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;
  pong_ball_if bus();
  pong_ball dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus.slave));
  typedef struct packed {
    logic [11:0] x1, x2, y1, y2;
    logic hit, miss;
    logic [7:0] score;
    logic [1:0] st, lives;
  } obs_t;
  obs_t sb[$];
  int n_vec = 0, n_err = 0;
  int mx, my, mdx, mdy, mst, mcnt, msc, mli;
  bit mh, mm;
  function automatic obs_t model_out();
    obs_t e;
    e.x1 = 12'(mx - H);
    e.x2 = 12'(mx + H);
    e.y1 = 12'(my - H);
    e.y2 = 12'(my + H);
    e.hit = mh;
    e.miss = mm;
    e.score = 8'(msc);
    e.st = 2'(mst);
`ifdef PONG_BALL_LIVES_EN
    e.lives = 2'(mli);
`else
    e.lives = 2'd0;
`endif
    return e;
  endfunction
  function automatic obs_t dut_out();
    obs_t o;
    o.x1 = bus.o_x1;
    o.x2 = bus.o_x2;
    o.y1 = bus.o_y1;
    o.y2 = bus.o_y2;
    o.hit = bus.o_hit;
    o.miss = bus.o_miss;
    o.score = bus.o_score;
    o.st = bus.o_state;
`ifdef PONG_BALL_LIVES_EN
    o.lives = bus.o_lives;
`else
    o.lives = 2'd0;
`endif
    return o;
  endfunction
  task automatic model_step(input bit rst, input bit upd, input bit serve, input int px1, input int px2, input int py1);
    int nx, ndx, ny, ndy;
    bit ph;
    if (rst) begin
      mx = CXI; my = CYI; mdx = 1; mdy = -1; mst = 0; mcnt = 0; msc = 0; mh = 0; mm = 0; mli = 3;
      return;
    end
    mh = 0;
    mm = 0;
    if (!upd) return;
    if (mst == 0 || mst == 3) begin
      if (serve) begin
        if (mst == 3) begin mli = 3; msc = 0; end
        mcnt = 0; mst = 1; mdx = 1; mdy = -1;
      end
    end else if (mst == 1 && mcnt < SF) begin
      mcnt++;
    end else begin
      mst = 2;
      if (mdx < 0 && mx <= H + S) begin nx = H; ndx = 1; end
      else if (mdx > 0 && mx + H + S >= W - 1) begin nx = W - 1 - H; ndx = -1; end
      else begin nx = mx + S * mdx; ndx = mdx; end
      ph = mdy > 0 && my + H < py1 && my + H + S >= py1 && mx + H >= px1 && mx - H <= px2;
      ny = my + S * mdy;
      ndy = mdy;
      if (mdy < 0 && my <= H + S) begin ny = H; ndy = 1; end
      else if (ph) begin ny = py1 - H - 1; ndy = -1; mh = 1; if (msc < 255) msc++; end
      else if (mdy > 0 && my + H + S >= HT - 1) begin
        mm = 1; nx = CXI; ny = CYI;
`ifdef PONG_BALL_LIVES_EN
        mli--;
        mst = (mli == 0) ? 3 : 0;
`else
        mst = 0;
`endif
      end
      mx = nx; my = ny; mdx = ndx; mdy = ndy;
    end
  endtask
  task automatic tick(input string tag, input bit rst, input bit stb, input bit anim, input bit serve,
                      input int px1, input int px2, input int py1);
    obs_t e, o;
    i_rst = rst;
    bus.i_ani_stb = stb;
    bus.i_animate = anim;
    bus.i_serve = serve;
    bus.i_pad_x1 = 12'(px1);
    bus.i_pad_x2 = 12'(px2);
    bus.i_pad_y1 = 12'(py1);
    bus.i_pad_y2 = 12'(py1 + 20);
    model_step(rst, stb && anim, serve, px1, px2, py1);
    sb.push_back(model_out());
    @(posedge i_clk);
    #1;
    e = sb.pop_front();
    o = dut_out();
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic track(input string tag, input bit anim);
    tick(tag, 0, 1, anim, 0, (mx - 80 < 0) ? 0 : mx - 80, mx + 80, 40);
  endtask
  task automatic rally_miss(input string tag);
    int g;
    tick({tag, "_serve"}, 0, 1, 1, 1, 700, 720, 440);
    repeat (SF + 1) tick({tag, "_wait"}, 0, 1, 1, 0, 700, 720, 440);
    g = 0;
    while (!mm && g < 3000) begin
      tick({tag, "_fall"}, 0, 1, 1, 0, 700, 720, 440);
      g++;
    end
    chk({tag, "_miss_pulse"}, int'(bus.o_miss), 1);
    chk({tag, "_miss_x1"}, int'(bus.o_x1), 312);
    tick({tag, "_after"}, 0, 0, 1, 0, 700, 720, 440);
    chk({tag, "_miss_clear"}, int'(bus.o_miss), 0);
  endtask
  initial begin
    int g;
    tick("reset", 1, 0, 0, 0, 0, 0, 440);
    tick("reset", 1, 1, 1, 1, 0, 0, 440);
    chk("rst_x1", int'(bus.o_x1), 312);
    chk("rst_x2", int'(bus.o_x2), 328);
    chk("rst_y1", int'(bus.o_y1), 232);
    chk("rst_y2", int'(bus.o_y2), 248);
    chk("rst_state", int'(bus.o_state), 0);
    chk("rst_score", int'(bus.o_score), 0);
    repeat (3) tick("idle", 0, 1, 1, 0, 0, 160, 440);
    tick("serve_nostb", 0, 0, 1, 1, 0, 160, 440);
    tick("serve", 0, 1, 1, 1, 0, 160, 440);
    for (int i = 0; i < SF; i++) begin
      tick("serve_cnt", 0, 1, 1, 0, 0, 160, 440);
      tick("serve_gap", 0, 1, 0, 0, 0, 160, 440);
    end
    chk("serve_state", int'(bus.o_state), 1);
    chk("serve_still", int'(bus.o_x1), 312);
    tick("first_move", 0, 1, 1, 0, 0, 160, 440);
    chk("move_state", int'(bus.o_state), 2);
    chk("move_x1", int'(bus.o_x1), 314);
    chk("move_y1", int'(bus.o_y1), 230);
    g = 0;
    while (msc < 255 && g < 20000) begin
      track("hits", 1);
      g++;
    end
    chk("score_reach", int'(bus.o_score), 255);
    repeat (200) track("sat", 1);
    chk("score_sat", int'(bus.o_score), 255);
    repeat (100) track("freeze", 0);
    chk("freeze_state", int'(bus.o_state), 2);
    repeat (20) track("resume", 1);
    rally_miss("miss1");
    chk("miss1_state", int'(bus.o_state), 0);
`ifdef PONG_BALL_LIVES_EN
    rally_miss("miss2");
    rally_miss("miss3");
    chk("over_state", int'(bus.o_state), 3);
    tick("over_serve", 0, 1, 1, 1, 700, 720, 440);
    chk("over_lives", int'(bus.o_lives), 3);
    chk("over_score", int'(bus.o_score), 0);
`else
    chk("score_kept", int'(bus.o_score), 255);
    tick("reserve", 0, 1, 1, 1, 700, 720, 440);
`endif
    repeat (SF + 30) tick("midplay", 0, 1, 1, 0, 700, 720, 440);
    tick("mid_reset", 1, 1, 1, 1, 0, 640, 440);
    chk("mid_rst_x1", int'(bus.o_x1), 312);
    chk("mid_rst_state", int'(bus.o_state), 0);
    chk("mid_rst_hit", int'(bus.o_hit), 0);
    chk("mid_rst_miss", int'(bus.o_miss), 0);
    tick("post_reset", 0, 0, 1, 0, 0, 640, 440);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
